score_player: RTL and testbench
===============================

Name: score_player

Overview:
- Responder end of the control FSM's playback handshake.
- Started by Do_rand_audio_video or Do_save_audio_video. Walks the selected score memory (random or saved) from address 0.
- Drives each note code to the audio/video stage for its stored length. Reports completion on Done_rand_audio / Done_save_audio.
- Sits between the control FSM, the two score memories and the audio/video note decoder.

Parameters:
- NOTE_W, 4, width of a note code; code 0 = rest.
- LEN_W, 3, width of a stored note length in beat units.
- SCORE_LEN, 16, notes per score; addresses 0..SCORE_LEN-1.
- ADDR_W, 4, score address width; must satisfy 2**ADDR_W >= SCORE_LEN.
- TICKS_PER_UNIT, 4, clk cycles per beat unit (prescaler terminal count).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- Init_audio_video  in  1  clear address/counters, return to IDLE
- Do_rand_audio_video  in  1  level request: play random score
- Do_save_audio_video  in  1  level request: play saved score
- End_early  in  1  user abort of current playback
- score_addr  out  ADDR_W  read address to both score memories
- rand_note  in  NOTE_W  random-score memory note data
- rand_len  in  LEN_W  random-score memory length data
- save_note  in  NOTE_W  saved-score memory note data
- save_len  in  LEN_W  saved-score memory length data
- note_out  out  NOTE_W  current note to audio/video stage
- note_valid  out  1  high while a non-rest note is sounding
- Done_rand_audio  out  1  random score finished
- Done_save_audio  out  1  saved score finished

Behaviour:
- Reset is synchronous and active-high on clk. One clock domain.
- Reset values: score_addr=0, note_out=0, note_valid=0, Done_rand_audio=0, Done_save_audio=0, state=IDLE, src=RAND, counters=0.
- Memories are synchronous read: data is valid the cycle after score_addr is presented.

States:
- IDLE:
  - If Do_rand_audio_video, latch src=RAND and go to FETCH.
  - Else if Do_save_audio_video, latch src=SAVE and go to FETCH.
  - Rand wins when both requests are high.
  - score_addr is not changed in IDLE.
- FETCH:
  - One cycle. score_addr is stable. note_out=0, note_valid=0. Go to LOAD.
- LOAD:
  - Capture note and length from the src memory. Go to PLAY.
  - On the entry edge, note_out=note and note_valid=(note!=0).
  - A stored length of 0 is treated as 1.
- PLAY:
  - note_out is held for exactly len*TICKS_PER_UNIT cycles, using a tick prescaler and a unit down-counter.
  - On expiry with score_addr==SCORE_LEN-1: go to DONE.
  - On expiry otherwise: score_addr+1, go to FETCH.
  - score_addr never wraps past SCORE_LEN-1.
- DONE:
  - note_out=0, note_valid=0.
  - Done_rand_audio=(src==RAND), Done_save_audio=(src==SAVE), held as a level.
  - When the active Do_* input is low: go to IDLE, drop Done, score_addr=0.
- Gap between notes: 2 silent cycles (FETCH + LOAD).

Priorities and boundary cases:
- End_early in FETCH/LOAD/PLAY: next cycle go to DONE with the current src. note_out=0 in the same transition.
- End_early in IDLE or DONE: no effect.
- Init_audio_video in any state: next cycle state=IDLE, score_addr=0, counters=0, note_out=0, Done=0.
- Priority order: reset > Init_audio_video > End_early > normal transitions.
- Do_* dropping mid-play (without End_early or Init): ignored; playback continues to DONE.
- Replay: control asserts Init_audio_video, then Do_rand_audio_video. The score restarts at address 0.
- Latency from Do_* rising in IDLE to the first note on note_out: 3 cycles (IDLE→FETCH→LOAD→PLAY).

Optional Feature:
- Macro: SCORE_TERMINATOR_EN.
- Defined: a note code of all ones (2**NOTE_W-1) captured in LOAD is a terminator. Go directly to DONE without sounding it, so scores can be shorter than SCORE_LEN.
- Undefined: all-ones is an ordinary playable note; only address SCORE_LEN-1 ends the score.

Test Plan:
- Reset, then hold Do_rand_audio_video=1. Random mem holds note=i+1, len=1 at every address i (defaults) → note_out=1 appears 3 cycles after request, each note lasts 4 cycles with 2 silent gap cycles, Done_rand_audio rises after address 15 and stays high until Do drops.
- Saved mem addr0 note=5 len=3, addr1 note=0 len=2 → note_out=5, note_valid=1 for 12 cycles; then note_out=0, note_valid=0 for 8 cycles; Done_save_audio (not rand) at end.
- Both Do_rand_audio_video and Do_save_audio_video high in IDLE → rand memory played, Done_rand_audio asserted only.
- End_early pulsed during addr 3 of PLAY → next cycle note_out=0, Done_rand_audio=1; after Do drops, score_addr=0.
- Init_audio_video during addr 7 of PLAY, then Do_rand_audio_video → IDLE next cycle, replay starts at score_addr=0; stored len=0 plays for 4 cycles.
- With SCORE_TERMINATOR_EN, addr2 note=15 → Done after two notes, note 15 never driven. Without the macro, note 15 plays normally.

Source files
------------

// File: rtl/score_player.sv
// ---------------------------------------------------------------------------
// score_player
//
// Purpose:
//   Responder end of the control FSM's playback handshake. A level request
//   (Do_rand_audio_video or Do_save_audio_video) starts a walk of the chosen
//   score memory from address 0. Each stored note code goes to the
//   audio/video stage for its stored length in beat units. Completion is
//   reported as a level on Done_rand_audio / Done_save_audio until the
//   request drops.
//
// Handshake:
//   A request is accepted in IDLE. Done_* stays high while the active request
//   stays high. Dropping that request acknowledges completion, and the block
//   returns to IDLE with address 0. Rand wins when both requests are high.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   Init_audio_video      clear address/counters, return to IDLE
//   Do_rand_audio_video   level request: play random score
//   Do_save_audio_video   level request: play saved score
//   End_early             abort current playback (go to DONE)
//   score_addr            read address to both score memories
//   rand_note/rand_len    random-score memory data (synchronous read)
//   save_note/save_len    saved-score memory data (synchronous read)
//   note_out              current note code to audio/video stage
//   note_valid            high while a non-rest note is sounding
//   Done_rand_audio       random score finished (level)
//   Done_save_audio       saved score finished (level)
//   dbg_state_o           current FSM state encoding (observation only)
//
// Build option:
//   SCORE_TERMINATOR_EN - when defined, an all-ones note code ends the score
//   without being sounded.
// ---------------------------------------------------------------------------
module score_player #(
    parameter int NOTE_W         = 4,
    parameter int LEN_W          = 3,
    parameter int SCORE_LEN      = 16,
    parameter int ADDR_W         = 4,
    parameter int TICKS_PER_UNIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Init_audio_video,
    input  logic              Do_rand_audio_video,
    input  logic              Do_save_audio_video,
    input  logic              End_early,
    output logic [ADDR_W-1:0] score_addr,
    input  logic [NOTE_W-1:0] rand_note,
    input  logic [LEN_W-1:0]  rand_len,
    input  logic [NOTE_W-1:0] save_note,
    input  logic [LEN_W-1:0]  save_len,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              Done_rand_audio,
    output logic              Done_save_audio,
    output logic [2:0]        dbg_state_o
);

    localparam int TICK_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCORE_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              src_save_q, src_save_d;   // 0 = random score, 1 = saved score
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              valid_q, valid_d;
    logic [TICK_W-1:0] tick_q, tick_d;           // beat-unit prescaler
    logic [LEN_W-1:0]  unit_q, unit_d;           // remaining beat units minus one

    logic [NOTE_W-1:0] mem_note;
    logic [LEN_W-1:0]  mem_len;
    logic              is_term;
    logic              req_active;

    assign mem_note   = src_save_q ? save_note : rand_note;
    assign mem_len    = src_save_q ? save_len  : rand_len;
    assign req_active = src_save_q ? Do_save_audio_video : Do_rand_audio_video;

`ifdef SCORE_TERMINATOR_EN
    assign is_term = &mem_note;
`else
    assign is_term = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_save_q <= 1'b0;
            addr_q     <= '0;
            note_q     <= '0;
            valid_q    <= 1'b0;
            tick_q     <= '0;
            unit_q     <= '0;
        end else begin
            state_q    <= state_d;
            src_save_q <= src_save_d;
            addr_q     <= addr_d;
            note_q     <= note_d;
            valid_q    <= valid_d;
            tick_q     <= tick_d;
            unit_q     <= unit_d;
        end
    end

    // Next-state logic. Init beats End_early, which beats normal sequencing.
    always_comb begin
        state_d    = state_q;
        src_save_d = src_save_q;
        addr_d     = addr_q;
        note_d     = note_q;
        valid_d    = valid_q;
        tick_d     = tick_q;
        unit_d     = unit_q;

        if (Init_audio_video) begin
            state_d = S_IDLE;
            addr_d  = '0;
            tick_d  = '0;
            unit_d  = '0;
            note_d  = '0;
            valid_d = 1'b0;
        end else if (End_early &&
                     (state_q == S_FETCH || state_q == S_LOAD || state_q == S_PLAY)) begin
            state_d = S_DONE;
            note_d  = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Do_rand_audio_video) begin
                        src_save_d = 1'b0;
                        state_d    = S_FETCH;
                    end else if (Do_save_audio_video) begin
                        src_save_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Address is already on the memories; data arrives in LOAD.
                    note_d  = '0;
                    valid_d = 1'b0;
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (is_term) begin
                        state_d = S_DONE;
                    end else begin
                        note_d  = mem_note;
                        valid_d = |mem_note;
                        tick_d  = TICK_LAST;
                        // A stored length of zero plays as one unit.
                        unit_d  = (mem_len == '0) ? '0 : mem_len - LEN_W'(1);
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tick_q != '0) begin
                        tick_d = tick_q - TICK_W'(1);
                    end else if (unit_q != '0) begin
                        unit_d = unit_q - LEN_W'(1);
                        tick_d = TICK_LAST;
                    end else begin
                        note_d  = '0;
                        valid_d = 1'b0;
                        if (addr_q == LAST_ADDR) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    note_d  = '0;
                    valid_d = 1'b0;
                    if (!req_active) begin
                        addr_d  = '0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        score_addr      = addr_q;
        note_out        = note_q;
        note_valid      = valid_q;
        Done_rand_audio = (state_q == S_DONE) && !src_save_q;
        Done_save_audio = (state_q == S_DONE) &&  src_save_q;
        dbg_state_o     = state_q;
    end

endmodule

// File: tb/tb_score_player.sv
// ---------------------------------------------------------------------------
// tb_score_player
//
// Bench for score_player. Both score memories are modelled here as
// synchronous-read arrays. For each playback the expected cycle-by-cycle
// observation {score_addr, Done_rand, Done_save, note_valid, note_out} is
// built from the memory contents and queued. Each cycle, one entry is popped
// and compared against the DUT.
// ---------------------------------------------------------------------------
module tb_score_player;

    localparam int NOTE_W = 4;
    localparam int LEN_W  = 3;
    localparam int SLEN   = 16;
    localparam int ADDR_W = 4;
    localparam int TPU    = 4;
    localparam int OBS_W  = ADDR_W + 3 + NOTE_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset, init, do_rand, do_save, end_early;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] score_addr;
    logic [NOTE_W-1:0] rand_note, save_note, note_out;
    logic [LEN_W-1:0]  rand_len, save_len;
    logic              note_valid, done_rand, done_save;
    logic [2:0]        dbg_state;

    score_player #(
        .NOTE_W(NOTE_W), .LEN_W(LEN_W), .SCORE_LEN(SLEN),
        .ADDR_W(ADDR_W), .TICKS_PER_UNIT(TPU)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Init_audio_video(init),
        .Do_rand_audio_video(do_rand),
        .Do_save_audio_video(do_save),
        .End_early(end_early),
        .score_addr(score_addr),
        .rand_note(rand_note),
        .rand_len(rand_len),
        .save_note(save_note),
        .save_len(save_len),
        .note_out(note_out),
        .note_valid(note_valid),
        .Done_rand_audio(done_rand),
        .Done_save_audio(done_save),
        .dbg_state_o(dbg_state)
    );

    // ---------------- score memories (synchronous read) ----------------
    logic [NOTE_W-1:0] rand_note_m [SLEN];
    logic [LEN_W-1:0]  rand_len_m  [SLEN];
    logic [NOTE_W-1:0] save_note_m [SLEN];
    logic [LEN_W-1:0]  save_len_m  [SLEN];

    always @(posedge clk) begin
        rand_note <= rand_note_m[score_addr];
        rand_len  <= rand_len_m[score_addr];
        save_note <= save_note_m[score_addr];
        save_len  <= save_len_m[score_addr];
    end

    // ---------------- scoreboard ----------------
    logic [OBS_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [OBS_W-1:0] pk(input logic [ADDR_W-1:0] a, input logic dr,
                                            input logic ds, input logic v,
                                            input logic [NOTE_W-1:0] n);
        return {a, dr, ds, v, n};
    endfunction

    function automatic logic [OBS_W-1:0] obs();
        return pk(score_addr, done_rand, done_save, note_valid, note_out);
    endfunction

    task automatic check_eq(input string tag, input logic [OBS_W-1:0] got,
                            input logic [OBS_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got addr=%0d dr=%b ds=%b v=%b note=%0d, expected addr=%0d dr=%b ds=%b v=%b note=%0d",
                     tag, $time, got[10:7], got[6], got[5], got[4], got[3:0],
                     exp[10:7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // Expected timeline from the request edge: per address two silent cycles
    // (FETCH, LOAD) then the note for len*TPU cycles; then DONE samples.
    task automatic build_expect(input bit save, input int n_done);
        int last;
        last = SLEN - 1;
        for (int i = 0; i < SLEN; i++) begin
            logic [NOTE_W-1:0] n;
            logic [LEN_W-1:0]  l;
            int units;
            n = save ? save_note_m[i] : rand_note_m[i];
            l = save ? save_len_m[i]  : rand_len_m[i];
            exp_q.push_back(pk(ADDR_W'(i), 1'b0, 1'b0, 1'b0, '0));
            exp_q.push_back(pk(ADDR_W'(i), 1'b0, 1'b0, 1'b0, '0));
`ifdef SCORE_TERMINATOR_EN
            if (n == 4'hF) begin
                last = i;
                break;
            end
`endif
            units = (l == 0) ? 1 : int'(l);
            repeat (units * TPU) exp_q.push_back(pk(ADDR_W'(i), 1'b0, 1'b0, (n != 0), n));
        end
        repeat (n_done) exp_q.push_back(pk(ADDR_W'(last), !save, save, 1'b0, '0));
    endtask

    // ---------------- driver ----------------
    // kind: 0 = normal, 1 = End_early pulse, 2 = Init pulse (request dropped),
    //       3 = request dropped mid-play (must be ignored)
    task automatic play(input bit want_rand, input bit want_save,
                        input int kind, input int abort_after);
        bit save;
        int idx;
        logic [OBS_W-1:0] e;
        logic [ADDR_W-1:0] a;
        save = !want_rand;
        exp_q.delete();
        build_expect(save, (kind == 3) ? 1 : 4);
        @(negedge clk);
        do_rand = want_rand;
        do_save = want_save;
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            end_early = 1'b0;
            init      = 1'b0;
            e = exp_q.pop_front();
            check_eq("seq", obs(), e);
            if (kind != 0 && idx == abort_after) begin
                a = e[10:7];
                @(negedge clk);
                case (kind)
                    1: begin
                        exp_q.delete();
                        end_early = 1'b1;
                        repeat (4) exp_q.push_back(pk(a, !save, save, 1'b0, '0));
                    end
                    2: begin
                        exp_q.delete();
                        init    = 1'b1;
                        do_rand = 1'b0;
                        do_save = 1'b0;
                        repeat (3) exp_q.push_back(pk('0, 1'b0, 1'b0, 1'b0, '0));
                    end
                    default: begin
                        do_rand = 1'b0;
                        do_save = 1'b0;
                    end
                endcase
            end
            idx++;
        end
        // Release the request: DONE must return to IDLE with address 0.
        @(negedge clk);
        do_rand = 1'b0;
        do_save = 1'b0;
        exp_q.push_back(pk('0, 1'b0, 1'b0, 1'b0, '0));
        @(posedge clk);
        #1;
        end_early = 1'b0;
        init      = 1'b0;
        check_eq("idle", obs(), exp_q.pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < SLEN; i++) begin
            rand_note_m[i] = NOTE_W'(i + 1);
            rand_len_m[i]  = LEN_W'(1);
            save_note_m[i] = NOTE_W'(i);
            save_len_m[i]  = LEN_W'(i % 4);
        end
        save_note_m[0] = 4'd5; save_len_m[0] = 3'd3;
        save_note_m[1] = 4'd0; save_len_m[1] = 3'd2;

        reset = 1'b1; init = 1'b0; do_rand = 1'b0; do_save = 1'b0; end_early = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", obs(), pk('0, 1'b0, 1'b0, 1'b0, '0));
        check_eq("reset_state", OBS_W'(dbg_state), '0);
        @(negedge clk);
        reset = 1'b0;

        play(1'b1, 1'b0, 0, 0);    // default random score
        play(1'b0, 1'b1, 0, 0);    // saved score incl. rest and len 0
        play(1'b1, 1'b1, 0, 0);    // both requests: rand wins
        play(1'b1, 1'b0, 1, 21);   // End_early during addr 3 PLAY
        play(1'b1, 1'b0, 2, 45);   // Init during addr 7 PLAY
        rand_len_m[0] = 3'd0;
        rand_len_m[5] = 3'd0;
        play(1'b1, 1'b0, 0, 0);    // replay from 0, zero lengths play one unit
        play(1'b1, 1'b0, 3, 30);   // request dropped mid-play is ignored
        rand_note_m[2] = 4'hF;
        play(1'b1, 1'b0, 0, 0);    // all-ones note (terminator when enabled)

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
